// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider: FSM states and control levels.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic RST_ENABLE            = 1'b1;
  localparam logic DIV_RESULT_READY      = 1'b1;
  localparam logic DIV_RESULT_NOT_READY  = 1'b0;
  localparam logic DIV_START             = 1'b1;
  localparam logic DIV_STOP              = 1'b0;

endpackage

// File: rtl/ex_div_div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < divisor_i, so the sign of the WIDTH+1 bit difference is a clean borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle iterative signed/unsigned divider for the EX stage; result is {remainder, quotient}.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_by_zero_o
);

  localparam int unsigned ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     dividend_q, dividend_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 qsign_q, qsign_d;
  logic                 rsign_q, rsign_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]          rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;

  // Dividend register doubles as quotient accumulator: dividend bits shift out the top,
  // quotient bits shift in at the bottom.
  assign rem_chain[0] = rem_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_chain[g]),
      .bit_i     (dividend_q[WIDTH-1-g]),
      .divisor_i (divisor_q),
      .rem_o     (rem_chain[g+1]),
      .q_o       (q_bits[BITS_PER_CYCLE-1-g])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    qsign_d    = qsign_q;
    rsign_d    = rsign_q;
    result_d   = result_q;
    dbz_d      = dbz_q;

    if (state_q != DIV_FREE && annul_i) begin
      state_d  = DIV_FREE;
      cnt_d    = '0;
      result_d = '0;
      dbz_d    = 1'b0;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state_d = DIV_BY_ZERO;
            end else begin
              state_d    = DIV_ON;
              cnt_d      = '0;
              rem_d      = '0;
              dividend_d = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
              divisor_d  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
              qsign_d    = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              rsign_d    = signed_div_i & opdata1_i[WIDTH-1];
            end
          end
        end
        DIV_BY_ZERO: begin
          state_d  = DIV_END;
          result_d = '0;
          dbz_d    = 1'b1;
        end
        DIV_ON: begin
          if (cnt_q == CNT_W'(ITER)) begin
            state_d  = DIV_END;
            dbz_d    = 1'b0;
            result_d = {rsign_q ? -rem_q : rem_q, qsign_q ? -dividend_q : dividend_q};
          end else begin
            rem_d      = rem_chain[BITS_PER_CYCLE];
            dividend_d = {dividend_q[WIDTH-BITS_PER_CYCLE-1:0], q_bits};
            cnt_d      = cnt_q + 1'b1;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state_d  = DIV_FREE;
            result_d = '0;
            dbz_d    = 1'b0;
          end
        end
        default: state_d = DIV_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      qsign_q    <= 1'b0;
      rsign_q    <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      qsign_q    <= qsign_d;
      rsign_q    <= rsign_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
    end
  end

  assign result_o      = result_q;
  assign ready_o       = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign div_by_zero_o = dbz_q;

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle iterative integer divider paired with the EX stage.
- Serves DIV/DIVU; the quotient goes to LO and the remainder to HI.
- EX holds start_i high and raises its stall request while the divider is busy; it releases both when ready_o is asserted.
- Parametrised successor of the single-cycle EX arithmetic:
  - configurable operand width;
  - configurable quotient bits retired per cycle;
  - pipeline-flush cancel;
  - explicit divide-by-zero flag.

Parameters:
- WIDTH, 32: operand width in bits.
- BITS_PER_CYCLE, 1: quotient bits produced per clock. Legal values are 1, 2 and 4. It must divide WIDTH evenly.
- ITER, WIDTH/BITS_PER_CYCLE: derived local parameter; number of iteration cycles.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst_n, input, 1: reset. Synchronous and active-high: asserted when equal to `RstEnable (1), despite the codebase's port name.
- signed_div_i, input, 1: 1 = signed (DIV), 0 = unsigned (DIVU). Sampled with start_i.
- opdata1_i, input, WIDTH: dividend.
- opdata2_i, input, WIDTH: divisor.
- start_i, input, 1: request. Level-held by EX until ready_o is seen.
- annul_i, input, 1: cancel on flush/exception. Has priority over everything except reset.
- result_o, output, 2*WIDTH: {remainder, quotient}.
- ready_o, output, 1: result_o is valid.
- div_by_zero_o, output, 1: the completed operation had divisor 0.

Behaviour:
- States (encodings in macro.v): DivFree, DivByZero, DivOn, DivEnd.
- Reset (rst_n = 1 at an edge) gives:
  - state DivFree, iteration counter 0;
  - result_o 0, ready_o 0, div_by_zero_o 0;
  - internal dividend, divisor and partial-remainder registers cleared.
  - Reset mid-operation aborts immediately; no partial result is ever visible.
- DivFree:
  - On start_i=1 and annul_i=0: capture the operands and signed_div_i.
  - If opdata2_i==0, go to DivByZero.
  - Otherwise go to DivOn. The operands are stored as magnitudes: two's-complement negate when signed and the MSB is 1. Record the quotient sign (XOR of MSBs) and remainder sign (dividend MSB). Clear the counter.
  - Otherwise stay in DivFree with ready_o=0.
- DivByZero: next edge goes to DivEnd with quotient=0, remainder=0, div_by_zero_o=1.
- DivOn:
  - Each cycle retires BITS_PER_CYCLE quotient bits, MSB first.
  - Each bit is one restoring step: shift the partial remainder left with the next dividend bit, trial-subtract the divisor at WIDTH+1 bits, keep the result if non-negative, and set the quotient bit to the inverted borrow.
  - The counter increments by 1 per cycle.
  - When the counter reaches ITER:
    - apply the sign corrections (negate the quotient if the quotient sign is 1; negate the remainder if the remainder sign is 1);
    - load result_o;
    - go to DivEnd.
- DivEnd:
  - ready_o=1; result_o and div_by_zero_o are held stable.
  - When start_i=0: go to DivFree next edge, clearing ready_o, result_o and div_by_zero_o.
  - While start_i stays 1, remain in DivEnd (this covers a stalled EX).
- Latency, counted from the edge that samples start_i:
  - normal operation: ready_o is high after ITER+2 edges (34 for the defaults);
  - divide by zero: ready_o is high after 2 edges.
- annul_i=1 in any state other than DivFree: go to DivFree next edge with outputs cleared. An annul in the same cycle as start_i in DivFree is ignored (stay in DivFree).
- start_i asserted while in DivOn or DivByZero is ignored. Operand changes during DivOn have no effect, because the operands were captured.
- Arithmetic rules:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN / -1 yields quotient=MIN and remainder=0, with no flag and no trap.
  - Unsigned mode never negates.

Decomposition:
- macro.v additions:
  - state encodings DivFree, DivByZero, DivOn, DivEnd;
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop;
  - DoubleRegBus is reused for result_o when WIDTH=32.
- Sub-module div_step: combinational, one restoring step. Inputs are the partial remainder, the next dividend bit and the divisor; outputs are the new remainder and the quotient bit. It is instantiated BITS_PER_CYCLE times in a chain inside ex_div.

Test Plan:
- Unsigned divide, 100 / 7 (signed_div_i=0), start held → ready_o=1 exactly 34 edges after start; result_o = {0x00000002, 0x0000000E}.
- Signed divide, -7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed MIN / -1 → quotient 0x80000000, remainder 0.
- Divide by zero, 5 / 0 → ready_o after 2 edges; result_o=0; div_by_zero_o=1. Drop start_i → ready_o=0 next edge.
- Cancel: assert annul_i at iteration 10 → DivFree next edge with ready_o=0. A new 9 / 3 then returns quotient 3, remainder 0 with no corruption from the annulled operation.
- Stall hold and reset: keep start_i high 5 cycles past ready_o → result_o stable and no restart; assert rst_n=1 mid-DivOn → all outputs 0 next edge.
- BITS_PER_CYCLE=4 build, 0xFFFFFFFF / 0x10 unsigned → ready after 10 edges; result_o = {0x0000000F, 0x0FFFFFFF}. Run a random signed/unsigned sweep against a reference model.
